// File: rtl/spi_sub_frame_rx.sv
// SPI mode-0 subordinate front-end: oversamples cs_n/sclk/mosi, strips a 2-bit key-size header,
// collects a 128/192/256-bit payload and shifts a response word out on miso. Option: SPI_SUB_STRICT_LEN_EN.
`timescale 1ns/1ps
module spi_sub_frame_rx #(
    parameter int TX_W        = 128,
    parameter int RX_W        = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs_n,
    input  logic            sclk,
    input  logic            mosi,
    output logic            miso,
    input  logic [TX_W-1:0] tx_data,
    output logic [RX_W-1:0] rx_data,
    output logic [1:0]      rx_hdr,
    output logic            rx_valid,
    output logic            rx_err,
    output logic            busy
);
    localparam int CNT_W = $clog2(RX_W) + 2;
    localparam int TXC_W = $clog2(TX_W) + 1;
    localparam int IDX_W = $clog2(RX_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_FLUSH,
        S_DECIDE,
        S_LOCKOUT
    } state_t;

    state_t state, next_state;

    // Top bit of each pipe is the history flop used for edge detection.
    logic [SYNC_STAGES:0] cs_pipe, sclk_pipe, mosi_pipe;
    logic cs_s, cs_hist, sclk_s, sclk_hist, mosi_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    logic [1:0]       hdr_q, hdr_next;
    logic             hdr_ok;
    logic [CNT_W-1:0] bit_cnt, n_req;
    logic             hdr_last, pay_last, len_ok, frame_good;
    logic [IDX_W-1:0] wr_idx;
    logic [RX_W-1:0]  rx_shift;
    logic [TX_W-1:0]  tx_shift;
    logic [TXC_W-1:0] tx_cnt;

    always_ff @(posedge clk) begin
        cs_pipe   <= {cs_pipe[SYNC_STAGES-1:0], cs_n};
        sclk_pipe <= {sclk_pipe[SYNC_STAGES-1:0], sclk};
        mosi_pipe <= {mosi_pipe[SYNC_STAGES-1:0], mosi};
    end

    assign cs_s      = cs_pipe[SYNC_STAGES-1];
    assign cs_hist   = cs_pipe[SYNC_STAGES];
    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign sclk_hist = sclk_pipe[SYNC_STAGES];
    assign mosi_s    = mosi_pipe[SYNC_STAGES];

    assign cs_fall   = cs_hist & ~cs_s;
    assign cs_rise   = ~cs_hist & cs_s;
    assign sclk_rise = sclk_s & ~sclk_hist & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_hist & ~cs_s;

    always_comb begin
        hdr_next = {hdr_q[0], mosi_s};
        unique case (hdr_q)
            2'b00:   n_req = CNT_W'(128);
            2'b01:   n_req = CNT_W'(192);
            default: n_req = CNT_W'(256);
        endcase
        hdr_last = (bit_cnt == CNT_W'(1));
        pay_last = (bit_cnt == n_req - CNT_W'(1));
        wr_idx   = IDX_W'(RX_W - 1) - bit_cnt[IDX_W-1:0];
`ifdef SPI_SUB_STRICT_LEN_EN
        len_ok   = (bit_cnt == n_req);
`else
        len_ok   = (bit_cnt >= n_req);
`endif
        frame_good = hdr_ok & len_ok;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (cs_fall) next_state = S_HDR;
            S_HDR: begin
                if (cs_rise)
                    next_state = S_DECIDE;
                else if (sclk_rise && hdr_last)
                    next_state = (hdr_next == 2'b11) ? S_FLUSH : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (cs_rise)
                    next_state = S_DECIDE;
                else if (sclk_rise && pay_last)
                    next_state = S_FLUSH;
            end
            S_FLUSH:   if (cs_rise) next_state = S_DECIDE;
            S_DECIDE:  next_state = S_IDLE;
            S_LOCKOUT: if (cs_s) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Reset lands in LOCKOUT so a frame already in progress is ignored until cs_n goes high.
    always_ff @(posedge clk) begin
        if (rst) state <= S_LOCKOUT;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q    <= '0;
            hdr_ok   <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_hdr   <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            busy     <= (next_state == S_HDR) || (next_state == S_PAYLOAD) ||
                        (next_state == S_FLUSH) || (next_state == S_DECIDE);
            case (state)
                S_IDLE: begin
                    if (cs_fall) begin
                        hdr_q    <= '0;
                        hdr_ok   <= 1'b0;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end
                end
                S_HDR: begin
                    if (sclk_rise) begin
                        hdr_q <= hdr_next;
                        if (hdr_last) begin
                            bit_cnt <= '0;
                            hdr_ok  <= (hdr_next != 2'b11);
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (sclk_rise) begin
                        rx_shift[wr_idx] <= mosi_s;
                        bit_cnt          <= bit_cnt + CNT_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (sclk_rise && (bit_cnt != '1))
                        bit_cnt <= bit_cnt + CNT_W'(1);
                end
                S_DECIDE: begin
                    if (frame_good) begin
                        rx_data  <= rx_shift;
                        rx_hdr   <= hdr_q;
                        rx_valid <= 1'b1;
                    end else begin
                        rx_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response shifter starts presenting on the first sclk fall after the header completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso     <= 1'b0;
            tx_shift <= '0;
            tx_cnt   <= '0;
        end else if (state == S_IDLE) begin
            miso <= 1'b0;
            if (cs_fall) begin
                tx_shift <= tx_data;
                tx_cnt   <= '0;
            end
        end else if (cs_s || ((state != S_PAYLOAD) && (state != S_FLUSH))) begin
            miso <= 1'b0;
        end else if (sclk_fall) begin
            if (tx_cnt != TXC_W'(TX_W)) begin
                miso     <= tx_shift[TX_W-1];
                tx_shift <= {tx_shift[TX_W-2:0], 1'b0};
                tx_cnt   <= tx_cnt + TXC_W'(1);
            end else begin
                miso <= 1'b0;
            end
        end
    end

endmodule
